// File: rtl/sd_wb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sd_wb_pkg
// Description : Shared widths, SD host register-map addresses, master FSM
//               state encoding and address-legality helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_wb_pkg;

  localparam int ADR_W  = 5;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  // Slave register map landmarks
  localparam logic [ADR_W-1:0] REG_MAX  = 5'd15;
  localparam logic [ADR_W-1:0] CMD_EXEC = 5'd16;
  localparam logic [ADR_W-1:0] FIFO_WR  = 5'd17;
  localparam logic [ADR_W-1:0] FIFO_RD  = 5'd18;
  localparam logic [ADR_W-1:0] DAT_EXEC = 5'd19;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    EXEC_WAIT = 3'd3,
    RESP      = 3'd4
  } wb_state_e;

  // Writes to these addresses start a command/data transfer and are followed
  // by a second, completion acknowledge.
  function automatic logic is_exec_adr(input logic [ADR_W-1:0] adr);
    return (adr == CMD_EXEC) || (adr == DAT_EXEC);
  endfunction

  // Reads may target plain registers or the read FIFO; writes may target
  // plain registers, the command trigger, the write FIFO or the data trigger.
  function automatic logic adr_is_legal(input logic we, input logic [ADR_W-1:0] adr);
    if (we) begin
      return (adr <= FIFO_WR) || (adr == DAT_EXEC);
    end
    return (adr <= REG_MAX) || (adr == FIFO_RD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_master_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Saturating wait counter with synchronous clear and a
//               "limit reached" flag against a run-time limit.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter
  import sd_wb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             reached_o
);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign reached_o = (count_q >= limit_i);

endmodule
`default_nettype wire

// File: rtl/wishbone_master.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_master
// Description : Single-transfer Wishbone initiator for the SD host register
//               map. One-cycle strobe per transfer, waits for the completion
//               ack on execute writes, reports data/error/timeout per request.
//               Optional macro WB_MASTER_ADR_CHECK_EN rejects illegal
//               addresses locally without a bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_master
  import sd_wb_pkg::*;
#(
  parameter int unsigned      ACK_TIMEOUT  = 8,
  parameter int unsigned      EXEC_TIMEOUT = 65535,
  parameter logic [ADR_W-1:0] PARK_ADR     = 5'h1F
) (
  input  logic              clock,
  input  logic              reset,
  // CPU-side request/response
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_error,
  output logic              resp_timeout,
  // Wishbone
  output logic              strobe,
  output logic              we_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ack_i,
  input  logic              error_i
);

  localparam logic [CNT_W-1:0] ACK_LIMIT  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] EXEC_LIMIT = CNT_W'(EXEC_TIMEOUT);

  wb_state_e         state_q, state_d;

  logic              strobe_q, strobe_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerror_q, rerror_d;
  logic              rtimeout_q, rtimeout_d;

  logic              w_adr_legal;
  logic              w_cnt_clear;
  logic              w_cnt_enable;
  logic [CNT_W-1:0]  w_cnt_limit;
  logic              w_reached;

`ifdef WB_MASTER_ADR_CHECK_EN
  assign w_adr_legal = adr_is_legal(req_we, req_adr);
`else
  assign w_adr_legal = 1'b1;
`endif

  // Counter restarts on every state change and only runs while waiting
  assign w_cnt_clear  = (state_d != state_q);
  assign w_cnt_enable = (state_q == WAIT_ACK) || (state_q == EXEC_WAIT);
  assign w_cnt_limit  = (state_q == EXEC_WAIT) ? EXEC_LIMIT : ACK_LIMIT;

  wb_timeout_counter u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (w_cnt_clear),
    .enable_i  (w_cnt_enable),
    .limit_i   (w_cnt_limit),
    .reached_o (w_reached)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, response capture and next-cycle bus/handshake values
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    rerror_d   = rerror_q;
    rtimeout_d = rtimeout_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          rdata_d    = '0;
          rerror_d   = 1'b0;
          rtimeout_d = 1'b0;
          if (w_adr_legal) begin
            state_d = ISSUE;
          end else begin
            state_d  = RESP;
            rerror_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_i) begin
          rdata_d  = we_q ? '0 : wb_data_i;
          rerror_d = error_i;
          state_d  = (we_q && is_exec_adr(adr_q)) ? EXEC_WAIT : RESP;
        end else if (w_reached) begin
          rtimeout_d = 1'b1;
          rerror_d   = 1'b1;
          state_d    = RESP;
        end
      end
      EXEC_WAIT: begin
        if (ack_i) begin
          state_d = RESP;
        end else if (w_reached) begin
          rtimeout_d = 1'b1;
          rerror_d   = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus is parked except while a transfer is being issued or acknowledged;
    // parking during EXEC_WAIT keeps the slave from re-executing.
    strobe_d = 1'b0;
    we_d     = 1'b0;
    adr_d    = PARK_ADR;
    wdata_d  = '0;
    case (state_d)
      ISSUE: begin
        strobe_d = 1'b1;
        we_d     = req_we;
        adr_d    = req_adr;
        wdata_d  = req_data;
      end
      WAIT_ACK: begin
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
      end
      default: begin
      end
    endcase

    ready_d  = (state_d == IDLE);
    rvalid_d = (state_d == RESP);
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_q   <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= PARK_ADR;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rerror_q   <= 1'b0;
      rtimeout_q <= 1'b0;
    end else begin
      strobe_q   <= strobe_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rerror_q   <= rerror_d;
      rtimeout_q <= rtimeout_d;
    end
  end

  assign strobe       = strobe_q;
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign wb_data_o    = wdata_q;
  assign req_ready    = ready_q;
  assign resp_valid   = rvalid_q;
  assign resp_data    = rdata_q;
  assign resp_error   = rerror_q;
  assign resp_timeout = rtimeout_q;

endmodule
`default_nettype wire

// File: doc/wishbone_master.md
Name: wishbone_master

Overview:
- Wishbone initiator that drives the SD host controller's Wishbone slave register map from a simple CPU-side request/response port.
- Sequences single read, write and execute transfers, and holds address, write-enable and data stable for the whole transfer.
- For execute addresses (CMD_EXEC=16, DAT_EXEC=19), waits for the second, completion acknowledge that the slave raises when the command or data transfer finishes.
- Reports read data, error and timeout per request.

Parameters:
- ACK_TIMEOUT, 8: maximum cycles to wait for the first ack after strobe.
- EXEC_TIMEOUT, 65535: maximum cycles to wait for the completion ack of an execute transfer.
- PARK_ADR, 5'h1F: address driven while the bus is idle or draining; it decodes to no side effect in the slave.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1=write or exec, 0=read
- req_adr  in  5  register address
- req_data  in  128  write data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  128  read data, 0 for writes
- resp_error  out  1  slave error or local reject
- resp_timeout  out  1  ack timeout
- strobe  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  5  Wishbone address
- wb_data_o  out  128  Wishbone write data
- wb_data_i  in  128  Wishbone read data
- ack_i  in  1  slave acknowledge
- error_i  in  1  slave error, valid with ack_i

Behaviour:
- Clock and reset: clock is clock; reset is synchronous, active-high. All outputs are registered.
- Reset values: strobe=0, we_o=0, adr_o=PARK_ADR, wb_data_o=0, req_ready=0, resp_valid=0, resp_data=0, resp_error=0, resp_timeout=0, state=IDLE, counter=0.
- States: IDLE, ISSUE, WAIT_ACK, EXEC_WAIT, RESP.
- IDLE:
  - req_ready=1; bus parked (strobe=0, we_o=0, adr_o=PARK_ADR).
  - On req_valid, capture we/adr/data and go to ISSUE.
- ISSUE (exactly one cycle):
  - strobe=1; we_o/adr_o/wb_data_o driven from the captured request.
  - Go to WAIT_ACK.
- Strobe is always a one-cycle pulse. The slave's ack is a Moore output one cycle after strobe, so holding strobe would cause a double FIFO/register access.
- WAIT_ACK:
  - strobe=0; we/adr/data held.
  - On ack_i, a read captures wb_data_i into resp_data, and error_i is captured into resp_error.
  - After ack_i: if we and adr is 16 or 19, go to EXEC_WAIT; otherwise go to RESP.
  - If the counter reaches ACK_TIMEOUT, set resp_timeout=1 and resp_error=1, then go to RESP.
- EXEC_WAIT:
  - strobe=0, we_o=0, adr_o=PARK_ADR, wb_data_o=0. This prevents the slave re-executing when it leaves its wait state.
  - On ack_i, go to RESP.
  - If the counter reaches EXEC_TIMEOUT, set timeout and error, then go to RESP. The slave may remain stuck; recovery is by reset.
- RESP (one cycle):
  - resp_valid=1; bus parked.
  - ack_i and error_i are ignored in this cycle (slave drain cycle).
  - Go to IDLE.
- Counter: 16-bit, cleared on every state change, saturates, never wraps.
- Latency (request accepted at edge T):
  - read/write: strobe in cycle T+1, ack seen in T+2, resp_valid in T+3.
  - exec: strobe in T+1, first ack in T+2, completion ack in T+2+n, resp_valid in T+3+n.
- Back-to-back: req_ready is high only in IDLE, giving a minimum of 4 cycles between accepted requests.
- ack_i outside WAIT_ACK and EXEC_WAIT is ignored.
- Reset mid-transfer: immediate return to IDLE with the bus parked; no response is issued.

Optional Feature:
- Macro: WB_MASTER_ADR_CHECK_EN.
- When defined, illegal requests are rejected locally from IDLE with no bus cycle: go straight to RESP with resp_error=1, so resp_valid is high the cycle after acceptance.
  - Legal reads: 0-15, 18.
  - Legal writes: 0-17, 19.
- When not defined, every request goes to the bus and errors come from error_i.

Decomposition:
- Shared package sd_wb_pkg holds:
  - address constants: REG_MAX=15, CMD_EXEC=16, FIFO_WR=17, FIFO_RD=18, DAT_EXEC=19;
  - the state enum;
  - the ADR_W=5 and DATA_W=128 widths.
- One sub-module, wb_timeout_counter: clear/enable inputs, saturating 16-bit count, reached flag compared against a limit input.

Test Plan:
- Read of reg 3, slave returns 128'hA5A5 with ack at T+2 -> resp_valid at T+3, resp_data=128'hA5A5, error=0; exactly one strobe cycle.
- Write to 17, data 128'h1234 -> one strobe; we_o=1, adr_o=17 held until ack; resp_valid with resp_data=0; slave fifo_write_en high for exactly 1 cycle.
- Exec write to 16, cmd_done after 20 cycles -> first ack, then we_o=0 and adr_o=5'h1F while waiting; resp_valid 1 cycle after the completion ack; new_command pulsed exactly once.
- Read of adr 20 without the macro -> error_i with ack -> resp_error=1. With WB_MASTER_ADR_CHECK_EN -> no strobe, resp_valid the cycle after acceptance, resp_error=1.
- No ack for 8 cycles -> resp_timeout=1, resp_error=1. Exec with no completion -> timeout after 65535 cycles.
- Reset asserted during EXEC_WAIT -> next cycle IDLE, strobe=0, adr_o=5'h1F, no resp_valid.
